// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for the pipelined ALU: op codes, FSM states
// and small op-classification functions used by the datapath.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NAND  = 4'd5,
    OP_NOR   = 4'd6,
    OP_XNOR  = 4'd7,
    OP_ADC   = 4'd8,
    OP_SBC   = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_SRA   = 4'd12,
    OP_MULL  = 4'd13,
    OP_MULH  = 4'd14,
    OP_PASSB = 4'd15
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Ops whose carry is written back into the persistent carry flag.
  function automatic logic is_arith(op_e o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_ADC) || (o == OP_SBC);
  endfunction

  // Ops that consume b as a shift amount.
  function automatic logic is_shift(op_e o);
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SRA);
  endfunction

  // Ops that run on the iterative multiplier instead of the one-cycle path.
  function automatic logic is_mul(op_e o);
    return (o == OP_MULL) || (o == OP_MULH);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier. A start pulse
// latches the operands; WIDTH steps later done rises and product is valid.
// done stays high until the next start so the consumer may stall.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand;
  // High half accumulates partial sums; low half starts as the multiplier
  // and is shifted out one bit per step as product bits shift in.
  logic [2*WIDTH-1:0] acc;
  logic [SHW-1:0]     count;
  logic               busy;
  logic [WIDTH:0]     sum;

  assign sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{acc[0]}}};
  assign product = acc;

  // Operand latch on start, then one add-and-shift step per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      acc   <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      count <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      acc <= {sum, acc[WIDTH-1:1]};
      if (count == SHW'(WIDTH - 1)) begin
        count <= '0;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with a registered result, NZCV flags and a persistent
// carry flag for multi-word ADC/SBC chains. Single-cycle ops complete on
// the accepting edge; MULL/MULH run on the iterative multiplier.
//
// Handshake: a transfer happens on any rising edge where valid and ready
// are both high on that side. in_ready is combinational from state,
// out_valid and out_ready; the result register holds while
// out_valid && !out_ready.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow,
  output state_e           fsm_state
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state;
  logic               cflag;
  logic               mul_high;
  op_e                op_in;
  logic               accept;
  logic               out_free;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [SHW-1:0]     shamt;
  logic               cin;
  logic [WIDTH-1:0]   res_y;
  logic               res_c;
  logic               res_v;
  logic [WIDTH-1:0]   mul_y;
  logic               mul_c;

  assign op_in     = op_e'(op);
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(op_in);
  assign fsm_state = state;

  assign shamt = is_shift(op_in) ? b[SHW-1:0] : '0;
  // Only the chaining ops fold the stored carry/borrow back in.
  assign cin   = ((op_in == OP_ADC) || (op_in == OP_SBC)) && cflag;

  assign mul_y = mul_high ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];
  assign mul_c = !mul_high && (|mul_product[2*WIDTH-1:WIDTH]);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // One-cycle result and flags for every non-multiply op.
  always_comb begin
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op_in)
      OP_ADD, OP_ADC: begin
        {res_c, res_y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (res_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB, OP_SBC: begin
        // Top bit of the WIDTH+1 difference is the borrow.
        {res_c, res_y} = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (res_y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:   res_y = a & b;
      OP_OR:    res_y = a | b;
      OP_XOR:   res_y = a ^ b;
      OP_NAND:  res_y = ~(a & b);
      OP_NOR:   res_y = ~(a | b);
      OP_XNOR:  res_y = ~(a ^ b);
      // An extra guard bit catches the last bit shifted out; it stays 0
      // for a zero shift amount.
      OP_SHL:   {res_c, res_y} = {1'b0, a} << shamt;
      OP_SHR:   {res_y, res_c} = {a, 1'b0} >> shamt;
      OP_SRA:   {res_y, res_c} = $signed({a, 1'b0}) >>> shamt;
      OP_PASSB: res_y = b;
      default: begin
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
      end
    endcase
  end

  // Control FSM plus result/flag registers and the persistent carry flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
      cflag     <= 1'b0;
      mul_high  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul(op_in)) begin
              mul_high <= (op_in == OP_MULH);
              state    <= MUL;
            end else begin
              y         <= res_y;
              carry     <= res_c;
              zero      <= (res_y == '0);
              negative  <= res_y[WIDTH-1];
              overflow  <= res_v;
              out_valid <= 1'b1;
              if (is_arith(op_in)) begin
                cflag <= res_c;
              end
            end
          end
        end
        MUL: begin
          // Never overwrite a result the consumer has not taken yet.
          if (mul_done && out_free) begin
            y         <= mul_y;
            carry     <= mul_c;
            zero      <= (mul_y == '0);
            negative  <= mul_y[WIDTH-1];
            overflow  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It has a configurable datapath width, a registered result with NZCV flags, and a persistent carry flag for ADC/SBC chaining. An iterative shift-add multiplier runs for WIDTH cycles. The block sits between an operand source and a result consumer, with valid/ready on both sides and full throughput for single-cycle ops.

## Interface
- WIDTH, 8, datapath width; power of two, 4..64
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand/op presented
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (shift amount = b[SHW-1:0])
- op  in  4  operation code
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes result
- y  out  WIDTH  result
- carry  out  1  carry/borrow/shifted-out bit of this result
- zero  out  1  y == 0
- negative  out  1  y[WIDTH-1]
- overflow  out  1  signed overflow of this result

## Operation
- Op codes:
  - 0 ADD: A+B
  - 1 SUB: A-B, carry = borrow
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NAND
  - 6 NOR
  - 7 XNOR
  - 8 ADC: A+B+cflag
  - 9 SBC: A-B-cflag, carry = borrow
  - 10 SHL
  - 11 SHR logical
  - 12 SRA
  - 13 MULL: low half of unsigned A*B
  - 14 MULH: high half of unsigned A*B
  - 15 PASSB: y = B
- Arithmetic: {carry,y} computed at WIDTH+1 bits. overflow = signed overflow (ADD/ADC: operands same sign, result differs; SUB/SBC: operands differ, result sign ≠ A).
- Logic/PASSB: carry = 0, overflow = 0.
- Shifts: carry = last bit shifted out; carry = 0 when amount is 0. overflow = 0.
- MULL: carry = (high half != 0). MULH: carry = 0. overflow = 0 for both.
- cflag: an internal register written with carry when an ADD/SUB/ADC/SBC result is loaded into the output register. No other op modifies it.
- FSM states:
  - IDLE: accept when in_valid && in_ready. Ops 0–12 and 15 load the result register on that edge. Ops 13/14 latch A, B and the half select, clear the accumulator, then go to MUL.
  - MUL: one shift-add step per cycle; counter runs 0..WIDTH-1. After the step with count = WIDTH-1, the next edge loads the result register, sets out_valid and returns to IDLE.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational.
- Result register and flags hold while out_valid && !out_ready. out_valid clears on out_ready with no new result loading.

## Timing
- Single-cycle ops: out_valid asserts on the edge that accepts the operation (latency 1). Back-to-back acceptance gives one result per cycle while out_ready = 1.
- MULL/MULH: out_valid asserts WIDTH+1 edges after the accept edge; in_ready = 0 throughout. The last MUL step must not overwrite an unconsumed result: MUL stalls in its final step until !out_valid || out_ready.
- Simultaneous out_ready and new accept: the old result is consumed, the new one is loaded on the same edge, and out_valid stays 1.
- ADC/SBC issued the cycle after ADD/SUB is accepted see the updated cflag.
- Reset values: out_valid = 0, y = 0, carry/zero/negative/overflow = 0, cflag = 0, state IDLE, counter 0. in_ready = 1 after reset.
- Reset asserted mid-MUL aborts the operation; no result is produced.

## Structure
- Package alu_pipe_pkg:
  - op_e enum (16 codes above)
  - state_e {IDLE, MUL}
  - is_arith/is_shift helper functions
- Sub-module alu_mul_seq: iterative WIDTH×WIDTH shift-add multiplier with start, done and 2·WIDTH product. alu_pipe owns the handshake, flags and cflag.

## Test plan
All scenarios at WIDTH = 8.
- ADD 0xFF+0x01 → y = 0x00, carry = 1, zero = 1, overflow = 0; out_valid one edge after accept.
- SUB 0x80-0x01 → y = 0x7F, carry = 0, overflow = 1. Then SUB 0x00-0x01 → y = 0xFF, carry = 1, negative = 1. Then SBC 0x05-0x02 → y = 0x02, cflag cleared.
- 16-bit chain 0x01FF+0x0001:
  - ADD 0xFF+0x01 → y = 0x00, carry = 1.
  - Back-to-back ADC 0x01+0x00 → y = 0x02.
  - Intervening XOR leaves cflag intact.
- MULL 0xFF×0xFF → y = 0x01, carry = 1; MULH 0xFF×0xFF → y = 0xFE. Each out_valid exactly 9 edges after accept, with in_ready = 0 during MUL.
- Shifts:
  - SHL 0x81 by 1 → y = 0x02, carry = 1.
  - SRA 0x90 by 2 → y = 0xE4, carry = 0.
  - SHR 0x03 by 0 → y = 0x03, carry = 0.
- Backpressure and reset:
  - Hold out_ready = 0 for 3 cycles: y and flags stable, in_ready = 0, no second accept. Release: next op accepted on the same edge.
  - Assert rst_n = 0 during MUL cycle 4: out_valid = 0, cflag = 0, and in_ready = 1 after release.
